paddsb_simd_pipe: RTL and testbench

Parametrised, pipelined sub-word-parallel saturating adder/subtractor for the Execute stage. Operates on LANES independent signed lanes of LANE_W bits each. Adds three things the 16-bit combinational PADDSB path lacks:
- a valid/ready handshake with two register stages;
- a selectable wrap (non-saturating) mode;
- a per-lane accumulator and sticky saturation flags for multi-cycle vector reductions.

---
 rtl/simd_pkg.sv | 15 +
 rtl/simd_lane_addsat.sv | 31 +++
 rtl/paddsb_simd_pipe.sv | 130 +++++++++++++
 tb/tb_paddsb_simd_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// simd_pkg: op encodings and in_op field positions shared by the SIMD
// saturating add/subtract pipe and its users.
package simd_pkg;

    // Full in_op encodings: bit0 selects subtract, bit1 selects wrap.
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDW = 2'b10;
    localparam logic [1:0] OP_SUBW = 2'b11;

    // Field positions inside in_op.
    localparam int OP_SUB_BIT  = 0;
    localparam int OP_WRAP_BIT = 1;

endpackage

// File: rtl/simd_lane_addsat.sv
// simd_lane_addsat: one signed lane of the SIMD adder. Computes A+B or A-B
// modulo 2^W, flags signed overflow, and clamps unless wrap is selected.
module simd_lane_addsat #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         wrap,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W-1:0] b_eff;
    logic [W-1:0] raw;
    logic [W-1:0] clamp;

    // Two's-complement negate of B for subtract; everything stays W bits wide.
    assign b_eff = sub ? (~b + W'(1)) : b;
    assign raw   = a + b_eff;

    // Overflow is judged on the original operand signs, so 0-(-8) is caught.
    assign ovf = (sub ? (a[W-1] != b[W-1]) : (a[W-1] == b[W-1]))
                 && (raw[W-1] != a[W-1]);

    // Clamp direction follows the sign of A: positive overflow -> max, negative -> min.
    assign clamp = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

    assign sum = (ovf && !wrap) ? clamp : raw;

endmodule

// File: rtl/paddsb_simd_pipe.sv
// paddsb_simd_pipe: two-stage valid/ready SIMD saturating/wrapping
// add/subtract with a per-lane accumulator and sticky saturation flags.
// Stage 1 registers operands; stage 2 computes and registers the result.
module paddsb_simd_pipe
    import simd_pkg::*;
#(
    parameter  int LANE_W = 4,
    parameter  int LANES  = 4,
    localparam int DATA_W = LANE_W * LANES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_op,
    input  logic              in_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LANES-1:0]  out_sat,
    output logic [LANES-1:0]  sat_sticky,
    input  logic              sat_clr
);

    // Stage-1 operand register
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_a_q;
    logic [DATA_W-1:0] s1_b_q;
    logic [1:0]        s1_op_q;
    logic              s1_acc_q;

    // Stage-2 result register, accumulator and sticky flags
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [LANES-1:0]  out_sat_q;
    logic [DATA_W-1:0] acc_q;
    logic [LANES-1:0]  sat_sticky_q;
    logic [LANES-1:0]  sat_sticky_d;

    // Handshake and datapath nets
    logic              adv2;
    logic              in_fire;
    logic              s2_load;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] lane_sum;
    logic [LANES-1:0]  lane_ovf;

    // Stage 2 can take a new result when empty or when its current one is leaving.
    assign adv2     = !out_valid_q || out_ready;
    assign in_ready = (!s1_valid_q || adv2) && !rst;
    assign in_fire  = in_valid && in_ready;
    assign s2_load  = s1_valid_q && adv2;

    // Accumulate beats read acc_q at compute time, so consecutive beats chain.
    assign op_a = s1_acc_q ? acc_q : s1_a_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        simd_lane_addsat #(
            .W (LANE_W)
        ) u_lane (
            .a    (op_a[l*LANE_W +: LANE_W]),
            .b    (s1_b_q[l*LANE_W +: LANE_W]),
            .sub  (s1_op_q[OP_SUB_BIT]),
            .wrap (s1_op_q[OP_WRAP_BIT]),
            .sum  (lane_sum[l*LANE_W +: LANE_W]),
            .ovf  (lane_ovf[l])
        );
    end

    // Stage-1 occupancy: set on accept, cleared when its beat moves on.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage-1 operand capture on every accepted beat.
    // NOTE: operand payload is not reset; it is only consumed while s1_valid_q is set.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_a_q   <= in_a;
            s1_b_q   <= in_b;
            s1_op_q  <= in_op;
            s1_acc_q <= in_acc;
        end
    end

    // Sticky next state: clear first, then OR in the beat entering stage 2.
    always_comb begin
        // NOTE: default assignment up front keeps every path driven, so no latch is inferred.
        sat_sticky_d = sat_clr ? '0 : sat_sticky_q;
        if (s2_load) begin
            sat_sticky_d = sat_sticky_d | lane_ovf;
        end
    end

    // Stage-2 result, accumulator and sticky update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sat_q    <= '0;
            acc_q        <= '0;
            sat_sticky_q <= '0;
        end else begin
            sat_sticky_q <= sat_sticky_d;
            if (adv2) begin
                out_valid_q <= s1_valid_q;
            end
            if (s2_load) begin
                out_data_q <= lane_sum;
                out_sat_q  <= lane_ovf;
                acc_q      <= lane_sum;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;
    assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_paddsb_simd_pipe.sv
// tb_paddsb_simd_pipe: directed vectors with literal expectations plus a
// transaction-level model checked against the DUT on every falling edge.
module tb_paddsb_simd_pipe;
    import simd_pkg::*;

    localparam int LW = 4;
    localparam int NL = 4;
    localparam int DW = LW * NL;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NL-1:0] sat;
    } res_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a      = '0;
    logic [DW-1:0] in_b      = '0;
    logic [1:0]    in_op     = 2'b00;
    logic          in_acc    = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [NL-1:0] out_sat;
    logic [NL-1:0] sat_sticky;
    logic          sat_clr   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    paddsb_simd_pipe #(
        .LANE_W (LW),
        .LANES  (NL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .sat_sticky (sat_sticky),
        .sat_clr    (sat_clr)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain signed integers, range-checked per lane.
    function automatic res_t ref_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input logic [1:0] op);
        res_t r;
        int   av, bv, s;
        int   max_v, min_v;
        max_v = (1 << (LW - 1)) - 1;
        min_v = -(1 << (LW - 1));
        r = '0;
        for (int l = 0; l < NL; l++) begin
            av = int'($signed(a[l*LW +: LW]));
            bv = int'($signed(b[l*LW +: LW]));
            s  = op[0] ? (av - bv) : (av + bv);
            if (s > max_v || s < min_v) begin
                r.sat[l] = 1'b1;
                if (!op[1]) s = (s > max_v) ? max_v : min_v;
            end
            r.data[l*LW +: LW] = s[LW-1:0];
        end
        return r;
    endfunction

    // Model state: queue of accepted results, oldest first.
    res_t          mq[$];
    bit            m_ov;
    bit            m_s1;
    logic [DW-1:0] m_acc = '0;
    logic [NL-1:0] m_sticky = '0;
    bit            m_adv, m_enter, m_accept, m_exp_ready;
    logic [NL-1:0] m_enter_sat;
    res_t          m_r;

    // Compare DUT to model on each falling edge, then advance model across the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_ov     = 1'b0;
            m_s1     = 1'b0;
            m_acc    = '0;
            m_sticky = '0;
            check("mdl_rst_out_valid", out_valid, 0);
            check("mdl_rst_in_ready", in_ready, 0);
            check("mdl_rst_sticky", sat_sticky, 0);
        end else begin
            m_exp_ready = !m_s1 || !m_ov || out_ready;
            check("mdl_in_ready", in_ready, m_exp_ready);
            check("mdl_out_valid", out_valid, m_ov);
            check("mdl_sticky", sat_sticky, m_sticky);
            if (m_ov) begin
                check("mdl_out_data", out_data, mq[0].data);
                check("mdl_out_sat", out_sat, mq[0].sat);
            end
            m_adv       = !m_ov || out_ready;
            m_enter     = m_adv && m_s1;
            m_enter_sat = m_enter ? mq[m_ov ? 1 : 0].sat : '0;
            m_sticky    = (sat_clr ? '0 : m_sticky) | m_enter_sat;
            if (m_ov && out_ready) void'(mq.pop_front());
            if (m_adv) m_ov = m_s1;
            m_accept = in_valid && m_exp_ready;
            if (m_accept) begin
                m_r   = ref_op(in_acc ? m_acc : in_a, in_b, in_op);
                m_acc = m_r.data;
                mq.push_back(m_r);
                m_s1 = 1'b1;
            end else if (m_enter) begin
                m_s1 = 1'b0;
            end
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [1:0] op, input logic acc, input string name);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_acc   = acc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check({name, "_accept"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the next valid result and check it against literals.
    task automatic expect_out(input string name, input logic [DW-1:0] d,
                              input logic [NL-1:0] s, output int waited);
        waited = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            waited++;
            if (out_valid) break;
        end
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, out_data, d);
        check({name, "_sat"}, out_sat, s);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, wa;
        #1 rst = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_sat", out_sat, 0);
        check("reset_sticky", sat_sticky, 0);
        check("reset_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("ready_after_reset", in_ready, 1);

        // Saturating add
        send(16'h783F, 16'h1F21, OP_ADD, 1'b0, "sat_add");
        expect_out("sat_add", 16'h7850, 4'b1100, w);
        check("sat_add_latency", w, 2);
        check("sat_add_sticky", sat_sticky, 4'b1100);

        // Saturating subtract
        send(16'h0872, 16'h81F5, OP_SUB, 1'b0, "sat_sub");
        expect_out("sat_sub", 16'h787D, 4'b1110, w);
        check("sat_sub_sticky", sat_sticky, 4'b1110);

        // Wrap add, then sticky clear
        send(16'h7777, 16'h1111, OP_ADDW, 1'b0, "wrap_add");
        expect_out("wrap_add", 16'h8888, 4'b1111, w);
        check("wrap_add_sticky", sat_sticky, 4'b1111);
        sat_clr = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        check("sticky_cleared", sat_sticky, 4'b0000);

        // Wrap subtract: -8 - 1 wraps to 7
        send(16'h8000, 16'h1000, OP_SUBW, 1'b0, "wrap_sub");
        expect_out("wrap_sub", 16'h7000, 4'b1000, w);

        // Accumulate chain from a fresh reset
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        fork
            begin
                send(16'hFFFF, 16'h3333, OP_ADD, 1'b1, "acc0");
                send(16'hFFFF, 16'h3333, OP_ADD, 1'b1, "acc1");
                send(16'hFFFF, 16'h3333, OP_ADD, 1'b1, "acc2");
            end
            begin
                expect_out("acc0", 16'h3333, 4'b0000, wa);
                expect_out("acc1", 16'h6666, 4'b0000, wa);
                expect_out("acc2", 16'h7777, 4'b1111, wa);
            end
        join

        // Backpressure: stall the consumer while three beats are offered
        out_ready = 1'b0;
        fork
            begin
                send(16'h1234, 16'h1111, OP_ADDW, 1'b0, "bp0");
                send(16'h7000, 16'h1000, OP_ADD, 1'b0, "bp1");
                send(16'h0F0F, 16'h0101, OP_SUB, 1'b0, "bp2");
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_full_in_ready", in_ready, 0);
                check("bp_stall_valid", out_valid, 1);
                check("bp_stall_data_a", out_data, 16'h2345);
                @(negedge clk);
                check("bp_stall_data_b", out_data, 16'h2345);
                check("bp_stall_sat", out_sat, 4'b0000);
                check("bp_still_full", in_ready, 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
                expect_out("bp0", 16'h2345, 4'b0000, wa);
                expect_out("bp1", 16'h7000, 4'b1000, wa);
                expect_out("bp2", 16'h0E0E, 4'b0000, wa);
            end
        join

        // Reset mid-flight with both stages full
        out_ready = 1'b0;
        send(16'h7777, 16'h1111, OP_ADDW, 1'b0, "mid0");
        send(16'h1234, 16'h1111, OP_ADD, 1'b0, "mid1");
        check("mid_pre_valid", out_valid, 1);
        check("mid_pre_sticky", sat_sticky, 4'b1111);
        check("mid_pre_full", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_sticky", sat_sticky, 0);
        check("mid_rst_in_ready", in_ready, 0);
        in_valid  = 1'b1;
        in_a      = 16'hABCD;
        in_b      = 16'h1111;
        in_op     = OP_ADD;
        in_acc    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        #1 check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        expect_out("post_rst_acc", 16'h1111, 4'b0000, w);
        check("post_rst_latency", w, 2);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
